// File: rtl/regfile_port_ctrl_pkg.sv
// rtl/regfile_port_ctrl_pkg.sv - shared widths and sequencer state encoding for the register file port controller
package regfile_port_ctrl_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    // Sequencer states, kept as a named enum so waveforms show them symbolically
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_port_ctrl.sv
// rtl/regfile_port_ctrl.sv - register file port sequencer; REGFILE_ZERO_REG_EN hard-wires register 0 to zero
module regfile_port_ctrl #(
    parameter int DATA_W = regfile_port_ctrl_pkg::DATA_W,
    parameter int ADDR_W = regfile_port_ctrl_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] rf_address_a,
    output logic [ADDR_W-1:0] rf_address_b,
    output logic              rf_write_enable,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [DATA_W-1:0] rf_data_a,
    input  logic [DATA_W-1:0] rf_data_b
);
    import regfile_port_ctrl_pkg::*;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_rf_address_a;
    logic [ADDR_W-1:0]   r_rf_address_b;
    logic                r_rf_write_enable;
    logic [DATA_W-1:0]   r_rf_write_data;
    logic                r_op_valid;
    logic [DATA_W-1:0]   r_op_a;
    logic [DATA_W-1:0]   r_op_b;

    logic                w_idle;
    logic                w_wb_accept;
    logic                w_rd_accept;
    logic                w_wb_we;
    logic [DATA_W-1:0]   w_rd_data_a;
    logic [DATA_W-1:0]   w_rd_data_b;

    // Handshakes only open in IDLE and never while reset is asserted; write-back wins over reads
    always_comb begin
        w_idle      = (r_state == ST_IDLE) && rst_n;
        wb_ready    = w_idle;
        rd_ready    = w_idle && !wb_valid;
        w_wb_accept = wb_ready && wb_valid;
        w_rd_accept = rd_ready && rd_valid;
    end

    // Register-0 handling: suppress the write strobe and zero the captured operand when enabled
    always_comb begin
`ifdef REGFILE_ZERO_REG_EN
        w_wb_we     = (wb_addr != '0);
        w_rd_data_a = (r_rf_address_a == '0) ? '0 : rf_data_a;
        w_rd_data_b = (r_rf_address_b == '0) ? '0 : rf_data_b;
`else
        w_wb_we     = 1'b1;
        w_rd_data_a = rf_data_a;
        w_rd_data_b = rf_data_b;
`endif
    end

    // Sequencer: serialise port-A use between write-back and operand reads
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state           <= ST_IDLE;
            r_rf_address_a    <= '0;
            r_rf_address_b    <= '0;
            r_rf_write_enable <= 1'b0;
            r_rf_write_data   <= '0;
            r_op_valid        <= 1'b0;
            r_op_a            <= '0;
            r_op_b            <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_wb_accept) begin
                        r_rf_address_a    <= wb_addr;
                        r_rf_write_data   <= wb_data;
                        r_rf_write_enable <= w_wb_we;
                        r_state           <= ST_WR;
                    end else if (w_rd_accept) begin
                        r_rf_address_a <= rd_addr_a;
                        r_rf_address_b <= rd_addr_b;
                        r_state        <= ST_RD;
                    end
                end
                ST_WR: begin
                    // The register file commits on this edge; drop the strobe behind it
                    r_rf_write_enable <= 1'b0;
                    r_state           <= ST_IDLE;
                end
                ST_RD: begin
                    // Read data was latched by the file on the preceding negedge
                    r_op_a     <= w_rd_data_a;
                    r_op_b     <= w_rd_data_b;
                    r_op_valid <= 1'b1;
                    r_state    <= ST_RSP;
                end
                ST_RSP: begin
                    if (op_ready) begin
                        r_op_valid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rf_address_a    = r_rf_address_a;
    assign rf_address_b    = r_rf_address_b;
    assign rf_write_enable = r_rf_write_enable;
    assign rf_write_data   = r_rf_write_data;
    assign op_valid        = r_op_valid;
    assign op_a            = r_op_a;
    assign op_b            = r_op_b;

endmodule
